wb_mp_ram: RTL and testbench

Single-clock, multi-port Wishbone RAM with 1 to 4 independent classic-cycle slave ports sharing one word array. Adds a non-power-of-two depth with error response for out-of-range addresses, selectable read latency of 1 or 2 cycles, and deterministic same-cycle write-collision resolution. Used as shared scratch or mailbox memory between several Wishbone masters in one clock domain.

---
 rtl/wb_mp_ram.sv | 116 +++++++++++
 tb/tb_wb_mp_ram.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mp_ram.sv
// Multi-port Wishbone classic-cycle RAM: PORTS slaves share one word array,
// with out-of-range error response, 1/2-cycle read latency and per-lane write merging.
module wb_mp_ram #(
  parameter int PORTS        = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*ADDR_WIDTH-1:0]   adr_i,
  input  logic [PORTS*DATA_WIDTH-1:0]   dat_i,
  output logic [PORTS*DATA_WIDTH-1:0]   dat_o,
  input  logic [PORTS-1:0]              we_i,
  input  logic [PORTS*SELECT_WIDTH-1:0] sel_i,
  input  logic [PORTS-1:0]              stb_i,
  input  logic [PORTS-1:0]              cyc_i,
  output logic [PORTS-1:0]              ack_o,
  output logic [PORTS-1:0]              err_o
);

  localparam int OFF    = $clog2(SELECT_WIDTH);
  localparam int IDX_W  = ADDR_WIDTH - OFF;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  // NOTE: the array has no reset; contents survive rst_n so committed writes persist.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PORTS-1:0]  wr_en;
  logic [MEM_AW-1:0] waddr [PORTS];

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    state_t                state;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] rd_buf;
    logic                  ack_q;
    logic                  err_q;
    logic [IDX_W-1:0]      idx;
    logic                  in_rng;
    logic                  accept;

    assign idx      = adr_i[p*ADDR_WIDTH+OFF +: IDX_W];
    assign in_rng   = {1'b0, idx} < DEPTH_L;
    assign accept   = (state == IDLE) && cyc_i[p] && stb_i[p];
    assign waddr[p] = idx[MEM_AW-1:0];
    assign wr_en[p] = accept && in_rng && we_i[p];

    if (OFF > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^adr_i[p*ADDR_WIDTH +: OFF];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= IDLE;
        ack_q  <= 1'b0;
        err_q  <= 1'b0;
        dat_q  <= '0;
        rd_buf <= '0;
      end else begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
        case (state)
          IDLE: begin
            if (accept) begin
              if (!in_rng) begin
                err_q <= 1'b1;
                state <= RESP;
              end else if (we_i[p]) begin
                ack_q <= 1'b1;
                state <= RESP;
              end else if (READ_LATENCY == 1) begin
                dat_q <= mem[waddr[p]];
                ack_q <= 1'b1;
                state <= RESP;
              end else begin
                rd_buf <= mem[waddr[p]];
                state  <= RD_WAIT;
              end
            end
          end
          RD_WAIT: begin
            dat_q <= rd_buf;
            ack_q <= 1'b1;
            state <= RESP;
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end

    assign dat_o[p*DATA_WIDTH +: DATA_WIDTH] = dat_q;
    assign ack_o[p] = ack_q;
    assign err_o[p] = err_q;
  end

  // Reads above sample the pre-write word on the same edge (read-first).
  always_ff @(posedge clk) begin
    // NOTE: ports are visited highest first so the lowest-index port's NBA lands last and wins the lane.
    for (int p = PORTS - 1; p >= 0; p--) begin
      if (wr_en[p]) begin
        for (int b = 0; b < SELECT_WIDTH; b++) begin
          if (sel_i[p*SELECT_WIDTH+b])
            mem[waddr[p]][b*8 +: 8] <= dat_i[p*DATA_WIDTH+b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mp_ram.sv
// Bench for wb_mp_ram: two instances (read latency 1 and 2, DEPTH 1000) share stimulus,
// compared against a transaction-level memory model with lowest-port-wins lane merging.
module tb_wb_mp_ram;

  localparam int P     = 2;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int SW    = 4;
  localparam int DEPTH = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [P*AW-1:0] adr;
  logic [P*DW-1:0] dat_w;
  logic [P*SW-1:0] sel;
  logic [P-1:0]    we, stb, cyc;
  logic [P*DW-1:0] dat_r1, dat_r2;
  logic [P-1:0]    ack1, ack2, err1, err2;

  wb_mp_ram #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
              .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_r1),
    .we_i(we), .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack1), .err_o(err1));

  wb_mp_ram #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
              .DEPTH(DEPTH), .READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_r2),
    .we_i(we), .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack2), .err_o(err2));

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] last_dat [2][P];

  logic        r_cyc [P];
  logic        r_stb [P];
  logic        r_we  [P];
  logic [15:0] r_adr [P];
  logic [31:0] r_dat [P];
  logic [3:0]  r_sel [P];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_ack(int d, int p);
    return (d == 0) ? ack1[p] : ack2[p];
  endfunction

  function automatic logic get_err(int d, int p);
    return (d == 0) ? err1[p] : err2[p];
  endfunction

  function automatic logic [31:0] get_dat(int d, int p);
    return (d == 0) ? dat_r1[p*DW +: DW] : dat_r2[p*DW +: DW];
  endfunction

  task automatic clr_reqs();
    for (int p = 0; p < P; p++) begin
      r_cyc[p] = 1'b0; r_stb[p] = 1'b0; r_we[p] = 1'b0;
      r_adr[p] = '0;   r_dat[p] = '0;   r_sel[p] = '0;
    end
  endtask

  task automatic set_req(input int p, input logic w, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    r_cyc[p] = 1'b1; r_stb[p] = 1'b1; r_we[p] = w;
    r_adr[p] = a;    r_dat[p] = d;    r_sel[p] = s;
  endtask

  // One transfer slot: present requests for one accept edge, then check every
  // response window of both instances and the final read data.
  task automatic run_xact();
    logic        acc [P];
    logic        oor [P];
    int          idx [P];
    logic [31:0] rd_val [P];
    int          rc;
    @(negedge clk);
    for (int p = 0; p < P; p++) begin
      adr[p*AW +: AW]   = r_adr[p];
      dat_w[p*DW +: DW] = r_dat[p];
      sel[p*SW +: SW]   = r_sel[p];
      we[p]  = r_we[p];
      cyc[p] = r_cyc[p];
      stb[p] = r_stb[p];
      acc[p] = r_cyc[p] && r_stb[p];
      idx[p] = int'(r_adr[p] >> 2);
      oor[p] = idx[p] >= DEPTH;
      rd_val[p] = '0;
      if (acc[p] && !oor[p] && !r_we[p])
        rd_val[p] = ref_mem.exists(idx[p]) ? ref_mem[idx[p]] : 32'h0;
    end
    for (int p = P - 1; p >= 0; p--) begin
      if (acc[p] && !oor[p] && r_we[p]) begin
        if (!ref_mem.exists(idx[p])) ref_mem[idx[p]] = 32'h0;
        for (int b = 0; b < SW; b++)
          if (r_sel[p][b]) ref_mem[idx[p]][b*8 +: 8] = r_dat[p][b*8 +: 8];
      end
    end
    @(posedge clk);
    #1;
    cyc = '0;
    stb = '0;
    for (int k = 1; k <= 3; k++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < P; p++) begin
          rc = (oor[p] || r_we[p]) ? 1 : d + 1;
          check($sformatf("ack l%0d p%0d k%0d", d + 1, p, k), 64'(get_ack(d, p)),
                64'(acc[p] && !oor[p] && k == rc));
          check($sformatf("err l%0d p%0d k%0d", d + 1, p, k), 64'(get_err(d, p)),
                64'(acc[p] && oor[p] && k == rc));
        end
      end
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < P; p++) begin
        if (acc[p] && !oor[p] && !r_we[p]) last_dat[d][p] = rd_val[p];
        check($sformatf("dat l%0d p%0d", d + 1, p), 64'(get_dat(d, p)), 64'(last_dat[d][p]));
      end
    end
    clr_reqs();
  endtask

  int win [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 32, 998, 999, 1000, 1001, 16383};

  initial begin
    rst_n = 1'b0;
    adr = '0; dat_w = '0; sel = '0; we = '0; stb = '0; cyc = '0;
    clr_reqs();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < P; p++) last_dat[d][p] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ack", 64'({ack1, ack2}), 64'h0);
    check("rst err", 64'({err1, err2}), 64'h0);
    check("rst dat", 64'(dat_r1 | dat_r2), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Give every in-range word of the address window a known value.
    for (int i = 0; i < 13; i++) begin
      set_req(0, 1'b1, 16'(win[i] << 2), $urandom, 4'hF);
      run_xact();
    end

    // Full write then read back.
    set_req(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF); run_xact();
    set_req(0, 1'b0, 16'h0010, 32'h0, 4'h0);        run_xact();
    check("t1 dat", 64'(dat_r1[31:0]), 64'hDEADBEEF);

    // Partial lanes 0 and 2.
    set_req(1, 1'b1, 16'h0010, 32'h11223344, 4'h5); run_xact();
    set_req(0, 1'b0, 16'h0012, 32'h0, 4'h0);        run_xact();
    check("t2 dat l1", 64'(dat_r1[31:0]), 64'hDE22BE44);
    check("t2 dat l2", 64'(dat_r2[31:0]), 64'hDE22BE44);

    // Same-edge write collision to word 0x20.
    set_req(0, 1'b1, 16'h0080, 32'hAAAAAAAA, 4'h3);
    set_req(1, 1'b1, 16'h0080, 32'hBBBBBBBB, 4'hF);
    run_xact();
    set_req(0, 1'b0, 16'h0080, 32'h0, 4'h0); run_xact();
    check("t3 dat", 64'(dat_r1[31:0]), 64'hBBBBAAAA);

    // Depth boundary: word 1000 errors, word 999 reads.
    set_req(1, 1'b0, 16'h0FA0, 32'h0, 4'hF); run_xact();
    set_req(1, 1'b1, 16'h0F9C, 32'hCAFEF00D, 4'hF); run_xact();
    set_req(1, 1'b0, 16'h0F9C, 32'h0, 4'hF); run_xact();
    check("t4 dat", 64'(dat_r2[63:32]), 64'hCAFEF00D);

    // Read-first on a same-edge read/write to word 3.
    set_req(0, 1'b1, 16'h000C, 32'h1234_0000, 4'hF); run_xact();
    set_req(0, 1'b1, 16'h000C, 32'h5, 4'hF);
    set_req(1, 1'b0, 16'h000C, 32'h0, 4'h0);
    run_xact();
    check("t5 old", 64'(dat_r2[63:32]), 64'h1234_0000);
    set_req(1, 1'b0, 16'h000C, 32'h0, 4'h0); run_xact();
    check("t5 new", 64'(dat_r2[63:32]), 64'h5);

    // Reset while the latency-2 instance sits in RD_WAIT.
    @(negedge clk);
    adr[AW-1:0] = 16'h0010; we[0] = 1'b0; sel[SW-1:0] = 4'hF;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk);
    #1;
    cyc = '0; stb = '0;
    rst_n = 1'b0;
    #1;
    check("t6 ack", 64'({ack1, ack2}), 64'h0);
    check("t6 dat", 64'(dat_r1 | dat_r2), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < P; p++) last_dat[d][p] = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t6 no ack", 64'({ack1, ack2, err1, err2}), 64'h0);
    end
    set_req(0, 1'b0, 16'h0010, 32'h0, 4'h0); run_xact();
    check("t6 keep", 64'(dat_r1[31:0]), 64'hDE22BE44);

    // Random traffic over a small window so collisions and boundaries recur.
    for (int n = 0; n < 200; n++) begin
      for (int p = 0; p < P; p++) begin
        r_cyc[p] = ($urandom_range(0, 7) != 0);
        r_stb[p] = ($urandom_range(0, 7) != 0);
        r_we[p]  = 1'($urandom_range(0, 1));
        r_adr[p] = 16'((win[$urandom_range(0, 15)] << 2) | $urandom_range(0, 3));
        r_dat[p] = $urandom;
        r_sel[p] = 4'($urandom_range(0, 15));
      end
      run_xact();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
